// File: rtl/reg_file_mp.sv
// reg_file_mp: parametrised 2-read / 1-write register file with a hardware
// zeroing sweep after reset and on Clear, and an optional hardwired-zero entry 0.
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-to-read forwarding).
// Ports:
//   CLK, Rst_n           clock, asynchronous active-low reset
//   Rd_Addr1/Rd_Data1    read port 1 (combinational data)
//   Rd_Addr2/Rd_Data2    read port 2 (combinational data)
//   Wr_Addr/Wr_Data      write address / data, qualified by Write_Reg
//   Clear                single-cycle request to re-zero the whole file
//   Busy                 high while sweeping or while Write_Reg is asserted
//   Wr_Drop              registered pulse: a write was discarded by a sweep
module reg_file_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic              CLK,
  input  logic              Rst_n,
  input  logic [ADDR_W-1:0] Rd_Addr1,
  input  logic [ADDR_W-1:0] Rd_Addr2,
  output logic [DATA_W-1:0] Rd_Data1,
  output logic [DATA_W-1:0] Rd_Data2,
  input  logic [ADDR_W-1:0] Wr_Addr,
  input  logic [DATA_W-1:0] Wr_Data,
  input  logic              Write_Reg,
  input  logic              Clear,
  output logic              Busy,
  output logic              Wr_Drop
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
  localparam bit ZR = (ZERO_REG != 0);

  typedef enum logic {INIT, READY} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              drop_d;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem [DEPTH];

  // State, sweep pointer and drop pulse registers
  always_ff @(posedge CLK or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= INIT;
      ptr_q   <= '0;
      Wr_Drop <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      Wr_Drop <= drop_d;
    end
  end

  // Next-state logic and selection of the single array write port
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    drop_d    = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = Wr_Addr;
    mem_wdata = Wr_Data;
    case (state_q)
      INIT: begin
        mem_we    = 1'b1;
        mem_waddr = ptr_q;
        mem_wdata = '0;
        drop_d    = Write_Reg;
        if (Clear) begin
          ptr_d = '0;
        end else if (ptr_q == LAST_PTR) begin
          state_d = READY;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + ADDR_W'(1);
        end
      end
      READY: begin
        // Clear wins over a same-cycle write, which is then reported as dropped
        if (Clear) begin
          state_d = INIT;
          ptr_d   = '0;
          drop_d  = Write_Reg;
        end else if (Write_Reg && !(ZR && (Wr_Addr == '0))) begin
          mem_we = 1'b1;
        end
      end
      default: begin
        state_d = INIT;
        ptr_d   = '0;
      end
    endcase
    // An edge taken while reset is asserted must not modify the array
    mem_we = mem_we & Rst_n;
  end

  // Storage array, intentionally not reset; the sweep clears it
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Read muxes: INIT and the hardwired zero entry override everything
  always_comb begin
    Rd_Data1 = '0;
    Rd_Data2 = '0;
    if (state_q == READY) begin
      if (!(ZR && (Rd_Addr1 == '0))) begin
        Rd_Data1 = mem[Rd_Addr1];
`ifdef REGFILE_BYPASS_EN
        // Forward only a write that will actually commit on this edge
        if (Write_Reg && !Clear && (Wr_Addr == Rd_Addr1)) Rd_Data1 = Wr_Data;
`endif
      end
      if (!(ZR && (Rd_Addr2 == '0))) begin
        Rd_Data2 = mem[Rd_Addr2];
`ifdef REGFILE_BYPASS_EN
        if (Write_Reg && !Clear && (Wr_Addr == Rd_Addr2)) Rd_Data2 = Wr_Data;
`endif
      end
    end
  end

  assign Busy = (state_q == INIT) | Write_Reg;

endmodule

// File: tb/tb_reg_file_mp.sv
// Testbench for reg_file_mp: two instances (hardwired zero on / off) share all
// inputs; outputs are checked against a behavioural model of the file.
module tb_reg_file_mp;

  logic        clk = 1'b0;
  logic        rst_n, we, clr;
  logic [4:0]  wa, a1, a2;
  logic [31:0] wd;
  logic [31:0] rd1_z, rd2_z, rd1_n, rd2_n;
  logic        busy_z, drop_z, busy_n, drop_n;

  int checks = 0;
  int errors = 0;

  // Behavioural model
  bit          sweeping = 1'b1;
  int          sweep_left = 32;
  logic [31:0] m_z [32];
  logic [31:0] m_n [32];
  logic        exp_drop = 1'b0;

  always #5 clk = ~clk;

  reg_file_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) u_dut_z (
    .CLK(clk), .Rst_n(rst_n), .Rd_Addr1(a1), .Rd_Addr2(a2),
    .Rd_Data1(rd1_z), .Rd_Data2(rd2_z), .Wr_Addr(wa), .Wr_Data(wd),
    .Write_Reg(we), .Clear(clr), .Busy(busy_z), .Wr_Drop(drop_z));

  reg_file_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0)) u_dut_n (
    .CLK(clk), .Rst_n(rst_n), .Rd_Addr1(a1), .Rd_Addr2(a2),
    .Rd_Data1(rd1_n), .Rd_Data2(rd2_n), .Wr_Addr(wa), .Wr_Data(wd),
    .Write_Reg(we), .Clear(clr), .Busy(busy_n), .Wr_Drop(drop_n));

  // Expected read data for the current inputs
  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit zr);
    if (sweeping) return 32'h0;
    if (zr && a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (we && !clr && wa == a) return wd;
`endif
    return zr ? m_z[a] : m_n[a];
  endfunction

  // Apply inputs mid-cycle and let combinational outputs settle
  task automatic drive(input logic r, input logic w, input logic [4:0] wa_i,
                       input logic [31:0] wd_i, input logic c,
                       input logic [4:0] x1, input logic [4:0] x2);
    @(negedge clk);
    rst_n = r; we = w; wa = wa_i; wd = wd_i; clr = c; a1 = x1; a2 = x2;
    #1;
  endtask

  // Advance one rising edge and update the model from the sampled inputs
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      sweeping = 1'b1; sweep_left = 32; exp_drop = 1'b0;
    end else begin
      exp_drop = we && (sweeping || clr);
      if (sweeping) begin
        if (clr) sweep_left = 32;
        else begin
          sweep_left--;
          if (sweep_left == 0) begin
            sweeping = 1'b0;
            for (int i = 0; i < 32; i++) begin m_z[i] = 32'h0; m_n[i] = 32'h0; end
          end
        end
      end else if (clr) begin
        sweeping = 1'b1; sweep_left = 32;
      end else if (we) begin
        m_n[wa] = wd;
        if (wa != 5'd0) m_z[wa] = wd;
      end
    end
  endtask

  task automatic test_reset();
    int busy_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd1, 5'd2);
      checks++;
      if (busy_z !== 1'b1 || rd1_z !== 32'h0 || rd2_z !== 32'h0 || drop_z !== 1'b0) begin
        errors++;
        $display("FAIL reset_state: busy=%b rd1=%h rd2=%h drop=%b, required busy=1 rd=0 drop=0",
                 busy_z, rd1_z, rd2_z, drop_z);
      end
      tick();
    end
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'($urandom), 5'($urandom));
      if (busy_z === 1'b1) busy_cnt++;
      checks++;
      if (busy_z !== (sweeping || we) || busy_n !== busy_z) begin
        errors++;
        $display("FAIL init_busy cycle %0d: got %b/%b required %b", i, busy_z, busy_n, sweeping);
      end
      tick();
    end
    checks++;
    if (busy_cnt != 32) begin
      errors++;
      $display("FAIL sweep_length: busy for %0d cycles, required 32", busy_cnt);
    end
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'(2 * i), 5'(2 * i + 1));
      checks++;
      if (rd1_z !== 32'h0 || rd2_z !== 32'h0 || rd1_n !== 32'h0 || rd2_n !== 32'h0) begin
        errors++;
        $display("FAIL zero_after_sweep addr %0d/%0d: got %h %h %h %h required 0",
                 2 * i, 2 * i + 1, rd1_z, rd2_z, rd1_n, rd2_n);
      end
      tick();
    end
  endtask

  task automatic test_write_read();
    drive(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd1, 5'd2);
    tick();
    drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 5'd5);
    checks++;
    if (rd1_z !== 32'hDEADBEEF || rd2_z !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL write_read5: got %h %h required deadbeef", rd1_z, rd2_z);
    end
    drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd6, 5'd5);
    checks++;
    if (rd1_z !== 32'h0 || rd2_z !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL read6: got %h %h required 0 deadbeef", rd1_z, rd2_z);
    end
    tick();
  endtask

  task automatic test_zero_reg();
    drive(1'b1, 1'b1, 5'd0, 32'h12345678, 1'b0, 5'd3, 5'd4);
    tick();
    drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
    checks++;
    if (rd1_z !== 32'h0 || rd2_z !== 32'h0) begin
      errors++;
      $display("FAIL zero_reg_on: got %h %h required 0", rd1_z, rd2_z);
    end
    checks++;
    if (rd1_n !== 32'h12345678 || rd2_n !== 32'h12345678) begin
      errors++;
      $display("FAIL zero_reg_off: got %h %h required 12345678", rd1_n, rd2_n);
    end
    tick();
  endtask

  task automatic test_bypass();
    logic [31:0] same_cycle;
`ifdef REGFILE_BYPASS_EN
    same_cycle = 32'hA5A5A5A5;
`else
    same_cycle = 32'h00000077;
`endif
    drive(1'b1, 1'b1, 5'd9, 32'h77, 1'b0, 5'd0, 5'd0);
    tick();
    drive(1'b1, 1'b1, 5'd9, 32'hA5A5A5A5, 1'b0, 5'd9, 5'd1);
    checks++;
    if (rd1_z !== same_cycle || rd1_n !== same_cycle) begin
      errors++;
      $display("FAIL same_cycle_read9: got %h %h required %h", rd1_z, rd1_n, same_cycle);
    end
    tick();
    drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd9, 5'd9);
    checks++;
    if (rd1_z !== 32'hA5A5A5A5 || rd2_n !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL next_cycle_read9: got %h %h required a5a5a5a5", rd1_z, rd2_n);
    end
    tick();
  endtask

  task automatic test_drop();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
    tick();
    for (int i = 0; i < 36; i++) begin
      if (i == 10) drive(1'b1, 1'b1, 5'd3, 32'hFFFFFFFF, 1'b0, 5'd3, 5'd3);
      else         drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd3, 5'd3);
      if (i == 11 || i == 12) begin
        checks++;
        if (drop_z !== (i == 11) || drop_n !== (i == 11)) begin
          errors++;
          $display("FAIL wr_drop cycle %0d: got %b/%b required %b", i, drop_z, drop_n, i == 11);
        end
      end
      tick();
    end
    drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd3, 5'd3);
    checks++;
    if (rd1_z !== 32'h0 || rd2_n !== 32'h0 || busy_z !== 1'b0) begin
      errors++;
      $display("FAIL drop_addr3: got %h %h busy=%b required 0 0 busy=0", rd1_z, rd2_n, busy_z);
    end
    tick();
  endtask

  task automatic test_clear();
    int busy_cnt;
    drive(1'b1, 1'b1, 5'd7, 32'h11, 1'b0, 5'd0, 5'd0);
    tick();
    drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7);
    checks++;
    if (rd1_z !== 32'h11) begin
      errors++;
      $display("FAIL read7_before_clear: got %h required 00000011", rd1_z);
    end
    tick();
    busy_cnt = 0;
    for (int i = 0; i < 36; i++) begin
      drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd7, 5'd7);
      if (busy_z === 1'b1) begin
        busy_cnt++;
        checks++;
        if (rd1_z !== 32'h0 || rd2_n !== 32'h0) begin
          errors++;
          $display("FAIL clear_read7 cycle %0d: got %h %h required 0", i, rd1_z, rd2_n);
        end
      end
      tick();
    end
    checks++;
    if (busy_cnt != 32) begin
      errors++;
      $display("FAIL clear_sweep_length: %0d cycles, required 32", busy_cnt);
    end
    // Second clear, then restart the sweep at its 20th cycle
    drive(1'b1, 1'b1, 5'd7, 32'h11, 1'b0, 5'd0, 5'd0);
    tick();
    drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7);
    tick();
    busy_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      drive(1'b1, 1'b0, 5'd0, 32'h0, i == 20, 5'd7, 5'd7);
      if (i <= 20) begin
        checks++;
        if (busy_z !== 1'b1) begin
          errors++;
          $display("FAIL restart_busy_pre cycle %0d: got %b required 1", i, busy_z);
        end
      end else if (busy_z === 1'b1) busy_cnt++;
      tick();
    end
    checks++;
    if (busy_cnt != 32) begin
      errors++;
      $display("FAIL restart_sweep_length: %0d cycles after restart, required 32", busy_cnt);
    end
    drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd7, 5'd7);
    checks++;
    if (rd1_z !== 32'h0 || rd1_n !== 32'h0) begin
      errors++;
      $display("FAIL final_read7: got %h %h required 0", rd1_z, rd1_n);
    end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic [4:0] x1, x2, w_a;
      x1  = 5'($urandom);
      x2  = 5'($urandom);
      w_a = ($urandom_range(0, 3) == 0) ? x1 : 5'($urandom);
      drive(1'b1, 1'($urandom), w_a, $urandom, $urandom_range(0, 49) == 0, x1, x2);
      checks++;
      if (rd1_z !== exp_rd(x1, 1'b1) || rd2_z !== exp_rd(x2, 1'b1)) begin
        errors++;
        $display("FAIL rand_read_z cycle %0d: got %h %h required %h %h",
                 i, rd1_z, rd2_z, exp_rd(x1, 1'b1), exp_rd(x2, 1'b1));
      end
      checks++;
      if (rd1_n !== exp_rd(x1, 1'b0) || rd2_n !== exp_rd(x2, 1'b0)) begin
        errors++;
        $display("FAIL rand_read_n cycle %0d: got %h %h required %h %h",
                 i, rd1_n, rd2_n, exp_rd(x1, 1'b0), exp_rd(x2, 1'b0));
      end
      checks++;
      if (busy_z !== (sweeping || we) || drop_z !== exp_drop || drop_n !== exp_drop) begin
        errors++;
        $display("FAIL rand_status cycle %0d: busy=%b drop=%b/%b required busy=%b drop=%b",
                 i, busy_z, drop_z, drop_n, sweeping || we, exp_drop);
      end
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0; we = 1'b0; clr = 1'b0; wa = '0; wd = '0; a1 = '0; a2 = '0;
    test_reset();
    test_write_read();
    test_zero_reg();
    test_bypass();
    test_drop();
    test_clear();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
